vga_sync_monitor: RTL and testbench

//  Receive-side counterpart of the VGA timing generator. Samples Hsync/Vsync on pixel strobes and measures line, frame and pulse lengths.

---
 rtl/vga_sync_monitor.sv | 249 ++++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_monitor
//  Description : Receive-side VGA timing checker. Samples hsync/vsync on pixel
//                strobes, measures line/frame/pulse lengths, locks onto a
//                stream with the expected timing and regenerates x/y/display.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        display,
    output logic        locked,
    output logic        frame_start,
    output logic        err,
    output logic [11:0] h_total,
    output logic [11:0] v_total,
    output logic [7:0]  err_count
);

    localparam logic [11:0] CNT_MAX   = 12'hFFF;
    localparam logic [11:0] H_TOTAL_C = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] V_TOTAL_C = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_C  = 12'(V_SYNC);
    localparam logic [11:0] H_LO      = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_HI      = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_LO      = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_HI      = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [4:0]  LOCK_C    = 5'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        bad_q, bad_d;          // current frame already saw a mismatch
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic [11:0] hwid_q, hwid_d;
    logic [11:0] vwid_q, vwid_d;
    logic [11:0] htot_q, htot_d;
    logic [11:0] vtot_q, vtot_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        disp_q, disp_d;
    logic        locked_q;
    logic        fs_q, fs_d;
    logic        err_q, err_d;
    logic [7:0]  errcnt_q, errcnt_d;
    logic        mismatch;

    logic        w_hs_act, w_vs_act, w_hs_was, w_vs_was;
    logic        w_h_lead, w_h_trail, w_v_lead, w_v_trail;
    logic        w_check, w_in_h, w_in_v;
    logic [11:0] w_hcnt_inc, w_vcnt_inc;

    assign w_hs_act   = (hsync == SYNC_POL);
    assign w_vs_act   = (vsync == SYNC_POL);
    assign w_hs_was   = (hs_prev_q == SYNC_POL);
    assign w_vs_was   = (vs_prev_q == SYNC_POL);
    assign w_h_lead   = pix_en &&  w_hs_act && !w_hs_was;
    assign w_h_trail  = pix_en && !w_hs_act &&  w_hs_was;
    assign w_v_lead   = pix_en &&  w_vs_act && !w_vs_was;
    assign w_v_trail  = pix_en && !w_vs_act &&  w_vs_was;
    // Timing is only judged once a frame boundary has been seen.
    assign w_check    = (state_q != SEARCH);
    assign w_hcnt_inc = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 12'd1;
    assign w_vcnt_inc = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 12'd1;
    assign w_in_h     = (hcnt_d >= H_LO) && (hcnt_d < H_HI);
    assign w_in_v     = (vcnt_d >= V_LO) && (vcnt_d < V_HI);

    // Counters, measurements and mismatch detection for the current sample.
    always_comb begin
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        hwid_d    = hwid_q;
        vwid_d    = vwid_q;
        htot_d    = htot_q;
        vtot_d    = vtot_q;
        errcnt_d  = errcnt_q;
        fs_d      = 1'b0;
        err_d     = 1'b0;
        mismatch  = 1'b0;
        if (pix_en) begin
            hs_prev_d = hsync;
            vs_prev_d = vsync;
            // Line closes first so a coincident vsync edge sees the old vcnt.
            if (w_h_lead) begin
                hcnt_d = '0;
                htot_d = w_hcnt_inc;
                vcnt_d = w_vcnt_inc;
                if (w_check && w_hcnt_inc != H_TOTAL_C) mismatch = 1'b1;
                if (w_check && w_vcnt_inc == CNT_MAX && vcnt_q != CNT_MAX) mismatch = 1'b1;
            end else begin
                hcnt_d = w_hcnt_inc;
                if (w_check && w_hcnt_inc == CNT_MAX && hcnt_q != CNT_MAX) mismatch = 1'b1;
            end
            if (w_h_lead) begin
                hwid_d = 12'd1;
            end else if (w_hs_act && hwid_q != CNT_MAX) begin
                hwid_d = hwid_q + 12'd1;
            end
            if (w_h_trail && w_check && hwid_q != H_SYNC_C) mismatch = 1'b1;
            if (w_v_lead) begin
                vtot_d = w_vcnt_inc;
                vcnt_d = '0;
                vwid_d = 12'd1;
                fs_d   = 1'b1;
                if (w_check && w_vcnt_inc != V_TOTAL_C) mismatch = 1'b1;
            end else if (w_h_lead && w_vs_act && vwid_q != CNT_MAX) begin
                vwid_d = vwid_q + 12'd1;
            end
            if (w_v_trail && w_check && vwid_q != V_SYNC_C) mismatch = 1'b1;
            err_d = mismatch;
            if (mismatch && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
        end
    end

    // Lock state machine: count clean frames, drop back on any mismatch.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (pix_en) begin
            case (state_q)
                SEARCH: begin
                    if (w_v_lead) begin
                        state_d = TRACK;
                        good_d  = '0;
                        bad_d   = 1'b0;
                    end
                end
                TRACK: begin
                    if (w_v_lead) begin
                        bad_d = 1'b0;
                        if (mismatch || bad_q) begin
                            good_d = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                            if ({1'b0, good_q} + 5'd1 >= LOCK_C) state_d = LOCKED;
                        end
                    end else if (mismatch) begin
                        good_d = '0;
                        bad_d  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        state_d = TRACK;
                        good_d  = '0;
                        bad_d   = !w_v_lead;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Regenerated raster position and display window from the updated counters.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        disp_d = disp_q;
        if (pix_en) begin
            x_d    = w_in_h ? 10'(hcnt_d - H_LO) : '0;
            y_d    = w_in_v ? 10'(vcnt_d - V_LO) : '0;
            disp_d = (state_d == LOCKED) && w_in_h && w_in_v;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEARCH;
            good_q    <= '0;
            bad_q     <= 1'b0;
            hs_prev_q <= ~SYNC_POL;
            vs_prev_q <= ~SYNC_POL;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hwid_q    <= '0;
            vwid_q    <= '0;
            htot_q    <= '0;
            vtot_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            disp_q    <= 1'b0;
            locked_q  <= 1'b0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
            errcnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hwid_q    <= hwid_d;
            vwid_q    <= vwid_d;
            htot_q    <= htot_d;
            vtot_q    <= vtot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            disp_q    <= disp_d;
            locked_q  <= (state_d == LOCKED);
            fs_q      <= fs_d;
            err_q     <= err_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign display     = disp_q;
    assign locked      = locked_q;
    assign frame_start = fs_q;
    assign err         = err_q;
    assign h_total     = htot_q;
    assign v_total     = vtot_q;
    assign err_count   = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vga_sync_monitor
//  Description : Directed self-checking bench for vga_sync_monitor using a
//                reduced 25x14 raster so several frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_monitor;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB; // 25
    localparam int VA = 8,  VF = 1, VS = 2, VB = 3, VT = VA + VF + VS + VB; // 14

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [9:0]  x, y;
    logic        display, locked, frame_start, err;
    logic [11:0] h_total, v_total;
    logic [7:0]  err_count;

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .display(display), .locked(locked),
        .frame_start(frame_start), .err(err),
        .h_total(h_total), .v_total(v_total), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int h;
        int ex;
        int ey;
        int ed;
    } vec_t;

    vec_t tbl[10];

    int checks = 0;
    int errors = 0;
    int gh = 0, gv = 0;      // raster position of the next generated sample
    int div = 1;             // clocks per pixel strobe
    bit pending = 1'b0;      // an idle gap is owed before the next strobe
    int fs_seen = 0, err_seen = 0;
    int fs0, err0;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_start === 1'b1) fs_seen++;
        if (err === 1'b1) err_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Non-strobe clocks carry random sync levels that must be ignored.
    task automatic idle_gap();
        for (int i = 1; i < div; i++) begin
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic raw_sample(input logic hs, input logic vs);
        if (pending) idle_gap();
        hsync  = hs;
        vsync  = vs;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en  = 1'b0;
        pending = 1'b1;
    endtask

    // Raster layout: sync, back porch, active, front porch.
    task automatic send_sample();
        raw_sample((gh < HS) ? 1'b0 : 1'b1, (gv < VS) ? 1'b0 : 1'b1);
        gh++;
        if (gh == HT) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end
    endtask

    // Send samples up to and including raster position (v,h).
    task automatic goto(input int v, input int h);
        while (!(gv == v && gh == h)) send_sample();
        send_sample();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        pix_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        gh      = 0;
        gv      = 0;
        pending = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 10; i++) begin
            goto(tbl[i].v, tbl[i].h);
            check($sformatf("x[%0d]", i), x, tbl[i].ex);
            check($sformatf("y[%0d]", i), y, tbl[i].ey);
            check($sformatf("display[%0d]", i), display, tbl[i].ed);
            if (div > 1) begin
                idle_gap();
                pending = 1'b0;
                check($sformatf("x_hold[%0d]", i), x, tbl[i].ex);
                check($sformatf("display_hold[%0d]", i), display, tbl[i].ed);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Locked frame positions: active window is h 7..22, v 5..12.
        tbl[0] = '{0, 7, 0, 0, 0};
        tbl[1] = '{2, 10, 3, 0, 0};
        tbl[2] = '{4, 15, 8, 0, 0};
        tbl[3] = '{5, 6, 0, 0, 0};
        tbl[4] = '{5, 7, 0, 0, 1};
        tbl[5] = '{5, 22, 15, 0, 1};
        tbl[6] = '{5, 23, 0, 0, 0};
        tbl[7] = '{9, 12, 5, 4, 1};
        tbl[8] = '{12, 22, 15, 7, 1};
        tbl[9] = '{13, 10, 3, 0, 0};

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_display", display, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_err", err, 0);
        check("rst_h_total", h_total, 0);
        check("rst_v_total", v_total, 0);
        check("rst_err_count", err_count, 0);
        @(negedge clk);
        rst = 1'b1;

        // Nominal stream, one strobe per clock
        err0 = err_seen;
        send_sample();
        check("edge1_frame_start", frame_start, 1);
        check("edge1_locked", locked, 0);
        send_sample();
        check("frame_start_one_clk", frame_start, 0);
        goto(0, 0);
        check("edge2_locked", locked, 0);
        check("edge2_v_total", v_total, VT);
        goto(0, 0);
        check("edge3_locked", locked, 1);
        check("edge3_frame_start", frame_start, 1);
        check("edge3_h_total", h_total, HT);
        check("edge3_v_total", v_total, VT);
        check("edge3_err_count", err_count, 0);
        run_table();
        check("nominal_err_pulses", err_seen - err0, 0);

        // One long line while locked
        goto(3, HT - 1);
        raw_sample(1'b1, 1'b1);
        send_sample();
        check("long_err", err, 1);
        check("long_locked", locked, 0);
        check("long_err_count", err_count, 1);
        check("long_h_total", h_total, HT + 1);
        send_sample();
        check("long_err_one_clk", err, 0);
        goto(0, 0);
        check("relock_f1_locked", locked, 0);
        goto(0, 0);
        check("relock_f2_locked", locked, 0);
        goto(0, 0);
        check("relock_locked", locked, 1);
        check("relock_err_count", err_count, 1);
        check("long_err_pulses", err_seen - err0, 1);

        // Asynchronous reset mid-line while locked
        goto(6, 10);
        #3;
        rst = 1'b0;
        #1;
        check("arst_x", x, 0);
        check("arst_y", y, 0);
        check("arst_display", display, 0);
        check("arst_locked", locked, 0);
        check("arst_h_total", h_total, 0);
        check("arst_v_total", v_total, 0);
        check("arst_err_count", err_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        pending = 1'b0;
        goto(0, 0);
        check("rearm_edgeA_locked", locked, 0);
        goto(0, 0);
        check("rearm_edgeB_locked", locked, 0);
        goto(0, 0);
        check("rearm_edgeC_locked", locked, 1);
        check("rearm_err_count", err_count, 0);

        // Pixel strobe every 4th clock
        do_reset();
        div  = 4;
        fs0  = fs_seen;
        err0 = err_seen;
        send_sample();
        check("div4_edge1_frame_start", frame_start, 1);
        goto(0, 0);
        check("div4_edge2_locked", locked, 0);
        goto(0, 0);
        check("div4_edge3_locked", locked, 1);
        check("div4_h_total", h_total, HT);
        check("div4_v_total", v_total, VT);
        run_table();
        check("div4_frame_start_pulses", fs_seen - fs0, 3);
        check("div4_err_pulses", err_seen - err0, 0);

        // hsync missing for 5000 samples while locked
        div  = 1;
        err0 = err_seen;
        repeat (5000) raw_sample(1'b1, 1'b1);
        check("nohs_err_pulses", err_seen - err0, 1);
        check("nohs_locked", locked, 0);
        check("nohs_display", display, 0);
        check("nohs_err_count", err_count, 1);
        check("nohs_x", x, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
